// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states, opcodes and ALU select codes for the program sequencer
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode decoder; opcodes 110/111 decode as NOP (all flags low)
module seq_decode
    import seq_pkg::*;
(
    input  logic [2:0] opcode_i,
    output logic       is_clr_o,
    output logic       is_lda_o,
    output logic       is_ldb_o,
    output logic       is_alu_o,
    output logic [1:0] alu_code_o,
    output logic       is_halt_o
);

    always_comb begin
        is_clr_o   = 1'b0;
        is_lda_o   = 1'b0;
        is_ldb_o   = 1'b0;
        is_alu_o   = 1'b0;
        alu_code_o = ALU_NONE;
        is_halt_o  = 1'b0;
        case (opcode_i)
            OP_CLR:  is_clr_o = 1'b1;
            OP_LDA:  is_lda_o = 1'b1;
            OP_LDB:  is_ldb_o = 1'b1;
            OP_ADD: begin
                is_alu_o   = 1'b1;
                alu_code_o = ALU_ADD;
            end
            OP_SUB: begin
                is_alu_o   = 1'b1;
                alu_code_o = ALU_SUB;
            end
            OP_HALT: is_halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/exec/wait/writeback controller for memory and A/B/ALU datapath
// Optional STEP_MODE_EN adds a step input that gates each FETCH.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int PROG_LEN = 6,
    parameter int ALU_LAT  = 1,
    parameter int OP_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
`ifdef STEP_MODE_EN
    input  logic            step,
`endif
    input  logic [OP_W-1:0] instr,
    input  logic [OP_W-1:0] inX,
    output logic [2:0]      count,
    output logic [OP_W-1:0] operand,
    output logic            op_clr,
    output logic            op_ld_a,
    output logic            op_ld_b,
    output logic [1:0]      alu_sel,
    output logic            op_ld_res,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] LAST_ADDR = 3'(PROG_LEN - 1);
    localparam logic [2:0] WAIT_INIT = (ALU_LAT > 0) ? 3'(ALU_LAT - 1) : 3'd0;

    state_t          state_q, state_d;
    logic [2:0]      count_q, count_d;
    logic [OP_W-1:0] operand_q, operand_d;
    logic [2:0]      ir_q, ir_d;
    logic [1:0]      alu_sel_q, alu_sel_d;
    logic [2:0]      wait_q, wait_d;
    logic            advance;
    logic            step_ok;

    logic            is_clr, is_lda, is_ldb, is_alu, is_halt;
    logic [1:0]      alu_code;

`ifdef STEP_MODE_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    if (OP_W > 3) begin : g_hi
        logic unused_instr_hi;
        assign unused_instr_hi = ^instr[OP_W-1:3];
    end

    seq_decode u_decode (
        .opcode_i   (ir_q),
        .is_clr_o   (is_clr),
        .is_lda_o   (is_lda),
        .is_ldb_o   (is_ldb),
        .is_alu_o   (is_alu),
        .alu_code_o (alu_code),
        .is_halt_o  (is_halt)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        operand_d = operand_q;
        ir_d      = ir_q;
        alu_sel_d = alu_sel_q;
        wait_d    = wait_q;
        advance   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d = 3'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (step_ok) begin
                    ir_d      = instr[2:0];
                    operand_d = inX;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (is_alu) begin
                    alu_sel_d = alu_code;
                    if (ALU_LAT > 0) begin
                        wait_d  = WAIT_INIT;
                        state_d = WAIT;
                    end else begin
                        state_d = WB;
                    end
                end else if (is_halt) begin
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = WB;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            WB: begin
                alu_sel_d = ALU_NONE;
                advance   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // The last program word finishes into DONE with count held, never wrapping.
        if (advance) begin
            if (count_q == LAST_ADDR) begin
                state_d = DONE;
            end else begin
                count_d = count_q + 3'd1;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= 3'd0;
            operand_q <= '0;
            ir_q      <= 3'd0;
            alu_sel_q <= ALU_NONE;
            wait_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            operand_q <= operand_d;
            ir_q      <= ir_d;
            alu_sel_q <= alu_sel_d;
            wait_q    <= wait_d;
        end
    end

    // Strobes are gated by rst so a reset arriving mid-instruction suppresses them immediately.
    assign op_clr    = ~rst & (state_q == EXEC) & is_clr;
    assign op_ld_a   = ~rst & (state_q == EXEC) & is_lda;
    assign op_ld_b   = ~rst & (state_q == EXEC) & is_ldb;
    assign op_ld_res = ~rst & (state_q == WB);

    assign count   = count_q;
    assign operand = operand_q;
    assign alu_sel = alu_sel_q;
    assign busy    = (state_q == FETCH) || (state_q == EXEC) || (state_q == WAIT) || (state_q == WB);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer at ALU_LAT 1, 0 and 3
module tb_program_sequencer;

    localparam int OP_W = 4;
    localparam int KP   = 3;

    localparam logic [2:0] K_CLR  = 3'd1;
    localparam logic [2:0] K_LDA  = 3'd2;
    localparam logic [2:0] K_LDB  = 3'd3;
    localparam logic [2:0] K_RES  = 3'd4;
    localparam logic [2:0] K_DONE = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] cnt;
        logic [3:0] opnd;
        logic [1:0] alu;
        logic [3:0] run;
        logic       busy;
        int         t;
    } ev_t;

    logic clk = 1'b0;
    logic rst, start, nop5;
    bit   mon_en = 1'b0;
`ifdef STEP_MODE_EN
    logic step;
`endif

    logic [2:0]      count_w   [3];
    logic [OP_W-1:0] operand_w [3];
    logic [OP_W-1:0] instr_w   [3];
    logic [OP_W-1:0] inx_w     [3];
    logic            clr_w [3], lda_w [3], ldb_w [3], res_w [3], busy_w [3], done_w [3];
    logic [1:0]      alu_w [3];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int run_c [3] = '{0, 0, 0};
    bit done_p [3] = '{1'b0, 1'b0, 1'b0};

    ev_t q0 [$];
    ev_t q1 [$];
    ev_t q2 [$];

    function automatic logic [7:0] mem(input logic [2:0] a, input logic nop_at_5);
        case (a)
            3'd0:    mem = {4'h0, 4'h0};
            3'd1:    mem = {4'h1, 4'h2};
            3'd2:    mem = {4'h2, 4'h3};
            3'd3:    mem = {4'h3, 4'h0};
            3'd4:    mem = {4'h4, 4'h0};
            3'd5:    mem = nop_at_5 ? {4'h6, 4'h0} : {4'h5, 4'h0};
            default: mem = {4'h6, 4'h0};
        endcase
    endfunction

    function automatic int lat(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        program_sequencer #(
            .PROG_LEN (6),
            .ALU_LAT  ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .OP_W     (OP_W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
`ifdef STEP_MODE_EN
            .step      (step),
`endif
            .instr     (instr_w[g]),
            .inX       (inx_w[g]),
            .count     (count_w[g]),
            .operand   (operand_w[g]),
            .op_clr    (clr_w[g]),
            .op_ld_a   (lda_w[g]),
            .op_ld_b   (ldb_w[g]),
            .alu_sel   (alu_w[g]),
            .op_ld_res (res_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g])
        );
        assign {instr_w[g], inx_w[g]} = mem(count_w[g], nop5);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    function automatic ev_t mk(input logic [2:0] kind, input logic [2:0] cnt, input logic [3:0] opnd,
                               input logic [1:0] alu, input logic [3:0] run, input logic busy, input int t);
        ev_t e;
        e.kind = kind; e.cnt = cnt; e.opnd = opnd; e.alu = alu; e.run = run; e.busy = busy; e.t = t;
        return e;
    endfunction

    task automatic push(input int g, input ev_t e);
        if (g == 0) q0.push_back(e);
        else if (g == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : ((g == 1) ? q1.size() : q2.size());
    endfunction

    function automatic ev_t pop(input int g);
        if (g == 0) return q0.pop_front();
        if (g == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    // Expected event cycles, relative to the cycle in which start is sampled.
    task automatic push_prog(input int base, input int cutoff, input bit stepm);
        for (int g = 0; g < 3; g++) begin
            int L;
            int o [6];
            L = lat(g);
            if (!stepm) begin
                o = '{2, 4, 6, 9 + L, 12 + 2 * L, 15 + 2 * L};
            end else begin
                o[0] = KP + 1;
                o[1] = KP + 5 + 1;
                o[2] = KP + 10 + 1;
                o[3] = KP + 15 + 2 + L;
                o[4] = (L == 3) ? KP + 25 + 5 : KP + 20 + 2 + L;
                o[5] = (L == 3) ? KP + 35 + 2 : KP + 25 + 2;
            end
            if (o[0] < cutoff) push(g, mk(K_CLR,  3'd0, 4'd0, 2'b00, 4'd0, 1'b1, base + o[0]));
            if (o[1] < cutoff) push(g, mk(K_LDA,  3'd1, 4'd2, 2'b00, 4'd0, 1'b1, base + o[1]));
            if (o[2] < cutoff) push(g, mk(K_LDB,  3'd2, 4'd3, 2'b00, 4'd0, 1'b1, base + o[2]));
            if (o[3] < cutoff) push(g, mk(K_RES,  3'd3, 4'd0, 2'b01, 4'(L + 1), 1'b1, base + o[3]));
            if (o[4] < cutoff) push(g, mk(K_RES,  3'd4, 4'd0, 2'b10, 4'(L + 1), 1'b1, base + o[4]));
            if (o[5] < cutoff) push(g, mk(K_DONE, 3'd5, 4'd0, 2'b00, 4'd0, 1'b0, base + o[5]));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int g = 0; g < 3; g++) begin
                ev_t a;
                ev_t e;
                logic [2:0] k;
                run_c[g] = (alu_w[g] != 2'b00) ? run_c[g] + 1 : 0;
                k = 3'd0;
                if (clr_w[g]) k = K_CLR;
                else if (lda_w[g]) k = K_LDA;
                else if (ldb_w[g]) k = K_LDB;
                else if (res_w[g]) k = K_RES;
                else if (done_w[g] && !done_p[g]) k = K_DONE;
                done_p[g] = done_w[g];
                if (k != 3'd0) begin
                    checks++;
                    if ($countones({clr_w[g], lda_w[g], ldb_w[g], res_w[g]}) > 1) begin
                        fails++;
                        $display("FAIL strobe_onehot dut=%0d got %b expected at most one strobe", g,
                                 {clr_w[g], lda_w[g], ldb_w[g], res_w[g]});
                    end
                    a = mk(k, count_w[g], operand_w[g], alu_w[g], 4'(run_c[g]), busy_w[g], cyc);
                    checks++;
                    if (qsize(g) == 0) begin
                        fails++;
                        $display("FAIL unexpected_event dut=%0d got kind=%0d cnt=%0d t=%0d expected no event",
                                 g, a.kind, a.cnt, a.t);
                    end else begin
                        e = pop(g);
                        if (a !== e) begin
                            fails++;
                            $display("FAIL event dut=%0d got kind=%0d cnt=%0d op=%0d alu=%0d run=%0d busy=%0d t=%0d expected kind=%0d cnt=%0d op=%0d alu=%0d run=%0d busy=%0d t=%0d",
                                     g, a.kind, a.cnt, a.opnd, a.alu, a.run, a.busy, a.t,
                                     e.kind, e.cnt, e.opnd, e.alu, e.run, e.busy, e.t);
                        end
                    end
                end
            end
        end
    end

    task automatic goto_k(input int base, input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        for (int g = 0; g < 3; g++) begin
            logic [14:0] v;
            v = {count_w[g], operand_w[g], clr_w[g], lda_w[g], ldb_w[g], alu_w[g], res_w[g],
                 busy_w[g], done_w[g]};
            checks++;
            if (v !== 15'd0) begin
                fails++;
                $display("FAIL %s dut=%0d outputs=%h expected 0", nm, g, v);
            end
        end
    endtask

    task automatic wait_done(input string nm);
        int i;
        i = 0;
        while (!(done_w[0] && done_w[1] && done_w[2]) && i < 80) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (!(done_w[0] && done_w[1] && done_w[2])) begin
            fails++;
            $display("FAIL %s timeout got done=%b%b%b expected 111", nm, done_w[0], done_w[1], done_w[2]);
        end
    endtask

    task automatic run_prog(input int cutoff, input bit poke);
        int base;
        @(negedge clk);
        start = 1'b1;
        base = cyc;
        push_prog(base, cutoff, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (done_w[g] !== 1'b0 || count_w[g] !== 3'd0) begin
                fails++;
                $display("FAIL restart dut=%0d got done=%b count=%0d expected done=0 count=0",
                         g, done_w[g], count_w[g]);
            end
        end
        if (poke) begin
            goto_k(base, 8);
            start = 1'b1;
            goto_k(base, 10);
            start = 1'b0;
        end
        if (cutoff < 99) begin
            goto_k(base, cutoff);
            rst = 1'b1;
            goto_k(base, cutoff + 1);
            check_zero("rst_mid");
            rst = 1'b0;
            repeat (12) @(negedge clk);
        end else begin
            wait_done("done");
        end
    endtask

    initial begin
        int base;
        rst   = 1'b1;
        start = 1'b0;
        nop5  = 1'b0;
`ifdef STEP_MODE_EN
        step  = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        check_zero("reset");

        run_prog(99, 1'b0);
        nop5 = 1'b1;
        run_prog(99, 1'b0);
        nop5 = 1'b0;
        run_prog(99, 1'b1);
        run_prog(13, 1'b0);
        run_prog(99, 1'b0);

`ifdef STEP_MODE_EN
        step = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base = cyc;
        push_prog(base, 99, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            goto_k(base, KP + 5 * n);
            if (n < 6) begin
                checks++;
                if (count_w[0] !== 3'(n)) begin
                    fails++;
                    $display("FAIL step_hold pulse=%0d got count=%0d expected %0d", n, count_w[0], n);
                end
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        wait_done("step_done");
        step = 1'b1;
`else
        base = cyc;
`endif

        repeat (5) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (qsize(g) != 0) begin
                fails++;
                $display("FAIL missing_events dut=%0d got %0d pending expected 0 (base %0d)", g, qsize(g), base);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
